// File: rtl/access_pkg.sv
// Shared types and helpers for the multi-user access controller.
// Build option: ACCESS_LOCKOUT_EN enables the failure lockout in access_control_multi.
package access_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_ENTER, S_CHECK, S_GRANTED, S_NEW_PW, S_LOCKED
  } state_e;

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Factory password: digit idx of user is user+idx+1 (caller truncates to DIGIT_W).
  function automatic int default_digit(input int user, input int idx);
    return user + idx + 1;
  endfunction

endpackage

// File: rtl/password_store.sv
// Per-user password flop array: sync write, registered read, async reset to factory values.
module password_store
  import access_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIGITS  = 4,
  parameter int USERS   = 4,
  localparam int UW     = idx_w(USERS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [UW-1:0]                   wr_addr,
  input  logic [DIGITS-1:0][DIGIT_W-1:0]  wr_data,
  input  logic [UW-1:0]                   rd_addr,
  output logic [DIGITS-1:0][DIGIT_W-1:0]  rd_data
);

  logic [DIGITS-1:0][DIGIT_W-1:0] mem_q [USERS];
  logic [DIGITS-1:0][DIGIT_W-1:0] mem_d [USERS];
  logic [DIGITS-1:0][DIGIT_W-1:0] rd_q, rd_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    rd_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int u = 0; u < USERS; u++)
        for (int i = 0; i < DIGITS; i++)
          mem_q[u][i] <= DIGIT_W'(default_digit(u, i));
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/access_control_multi.sv
// Multi-user keypad access controller: entry FSM, fail counting, password change.
// Build option: define ACCESS_LOCKOUT_EN to add the timed lockout after MAX_FAIL failures.
module access_control_multi
  import access_pkg::*;
#(
  parameter int DIGIT_W     = 4,
  parameter int DIGITS      = 4,
  parameter int USERS       = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024,
  localparam int UW         = idx_w(USERS),
  localparam int FW         = $clog2(MAX_FAIL + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic [UW-1:0]      user_id,
  input  logic               logout,
  input  logic               change_req,
  output logic               access_grant,
  output logic               busy,
  output logic               locked,
  output logic [FW-1:0]      fail_cnt
);

  localparam int CW = idx_w(DIGITS);

  if (DIGITS < 2)      begin : g_chk_digits $error("DIGITS must be >= 2");      end
  if (USERS < 2)       begin : g_chk_users  $error("USERS must be >= 2");       end
  if (MAX_FAIL < 1)    begin : g_chk_fail   $error("MAX_FAIL must be >= 1");    end
  if (LOCK_CYCLES < 1) begin : g_chk_lock   $error("LOCK_CYCLES must be >= 1"); end

  state_e                         state_q, state_d;
  logic [DIGITS-1:0][DIGIT_W-1:0] entry_q, entry_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [UW-1:0]                  user_q, user_d;
  logic [FW-1:0]                  fail_q, fail_d;
  logic                           wr_en;
  logic [DIGITS-1:0][DIGIT_W-1:0] rd_data;
  logic                           last_digit;

`ifdef ACCESS_LOCKOUT_EN
  localparam int LW = idx_w(LOCK_CYCLES);
  logic [LW-1:0] lock_q, lock_d;
`endif

  // Read address follows the latched user, so the slot is ready well before CHECK.
  password_store #(.DIGIT_W(DIGIT_W), .DIGITS(DIGITS), .USERS(USERS)) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (user_q),
    .wr_data (entry_d),
    .rd_addr (user_q),
    .rd_data (rd_data)
  );

  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    user_d  = user_q;
    fail_d  = fail_q;
    wr_en   = 1'b0;
`ifdef ACCESS_LOCKOUT_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      S_IDLE: if (!logout && digit_valid) begin
        entry_d    = '0;
        entry_d[0] = digit_in;
        user_d     = user_id;
        cnt_d      = CW'(1);
        state_d    = S_ENTER;
      end
      S_ENTER: begin
        if (logout) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (digit_valid) begin
          entry_d[cnt_q] = digit_in;
          cnt_d          = last_digit ? '0 : cnt_q + CW'(1);
          if (last_digit) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        entry_d = '0;
        if (entry_q == rd_data) begin
          fail_d  = '0;
          state_d = S_GRANTED;
        end else begin
          fail_d  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
          state_d = S_IDLE;
`ifdef ACCESS_LOCKOUT_EN
          if (fail_d == FW'(MAX_FAIL)) state_d = S_LOCKED;
`endif
        end
      end
      S_GRANTED: begin
        if (logout) state_d = S_IDLE;
        else if (change_req) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_NEW_PW;
        end
      end
      S_NEW_PW: begin
        if (logout) begin
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (digit_valid) begin
          // Store takes the completed word, including this final digit, on this edge.
          entry_d[cnt_q] = digit_in;
          cnt_d          = last_digit ? '0 : cnt_q + CW'(1);
          if (last_digit) begin
            wr_en   = 1'b1;
            state_d = S_GRANTED;
          end
        end
      end
`ifdef ACCESS_LOCKOUT_EN
      S_LOCKED: begin
        lock_d = lock_q + LW'(1);
        if (lock_q == LW'(LOCK_CYCLES - 1)) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      cnt_q   <= '0;
      user_q  <= '0;
      fail_q  <= '0;
`ifdef ACCESS_LOCKOUT_EN
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      user_q  <= user_d;
      fail_q  <= fail_d;
`ifdef ACCESS_LOCKOUT_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // The session stays open while a replacement password is being typed.
  assign access_grant = (state_q == S_GRANTED) || (state_q == S_NEW_PW);
  assign busy         = (state_q == S_CHECK);
  assign fail_cnt     = fail_q;
`ifdef ACCESS_LOCKOUT_EN
  assign locked       = (state_q == S_LOCKED);
`else
  assign locked       = 1'b0;
`endif

endmodule
